// File: rtl/imem_loader.sv
// Instruction fetch memory: loads a program over valid/ready, holds the core in reset until loaded, then serves inst combinationally from pc.
// Load accepts one word per cycle while in LOAD; ld_ready drops for HOLD/RUN, and reload returns to LOAD one edge later.
module imem_loader #(
  parameter int DEPTH     = 256,
  parameter int ADDR_WIDE = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        reload,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        core_nrst,
  output logic        load_done,
  output logic        load_err,
  output logic        pc_fault
);

  localparam logic [1:0]           S_LOAD   = 2'd0;
  localparam logic [1:0]           S_HOLD   = 2'd1;
  localparam logic [1:0]           S_RUN    = 2'd2;
  localparam logic [31:0]          NOP      = 32'h0000_0013;
  localparam logic [ADDR_WIDE:0]   LAST_IDX = (ADDR_WIDE+1)'(DEPTH-1);
  localparam logic [ADDR_WIDE:0]   ONE      = (ADDR_WIDE+1)'(1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [ADDR_WIDE:0]   r_count;
  logic [31:0]          r_mem [DEPTH];
  logic                 r_core_nrst;
  logic                 r_load_err;
  logic                 r_pc_fault;
  logic                 w_beat;
  logic                 w_fill;
  logic                 w_reload;
  logic                 w_aligned;
  logic                 w_in_range;
  logic                 w_hit;
  logic [ADDR_WIDE-1:0] w_idx;

  assign w_beat     = ld_valid && (r_state == S_LOAD);
  assign w_fill     = w_beat && (r_count == LAST_IDX);
  // reload is only meaningful once a program exists; in LOAD it is ignored
  assign w_reload   = reload && (r_state != S_LOAD);

  assign w_idx      = pc[ADDR_WIDE+1:2];
  assign w_aligned  = (pc[1:0] == 2'b00);
  assign w_in_range = (pc[31:ADDR_WIDE+2] == '0);
  assign w_hit      = (r_state == S_RUN) && w_aligned && w_in_range &&
                      ({1'b0, w_idx} < r_count);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_beat && (ld_last || w_fill)) w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = w_reload ? S_LOAD : S_RUN;
      S_RUN:   if (w_reload) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_LOAD;
      r_count     <= '0;
      r_core_nrst <= 1'b0;
      r_load_err  <= 1'b0;
      r_pc_fault  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_core_nrst <= (w_state_nxt == S_RUN);
      if (w_reload) begin
        r_count    <= '0;
        r_load_err <= 1'b0;
        r_pc_fault <= 1'b0;
      end else begin
        if (w_beat) r_count <= r_count + ONE;
        if (w_fill && !ld_last) r_load_err <= 1'b1;
        if ((r_state == S_RUN) && !(w_aligned && w_in_range)) r_pc_fault <= 1'b1;
      end
    end
  end

  // program storage survives reset; count alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_beat) r_mem[r_count[ADDR_WIDE-1:0]] <= ld_data;
  end

  assign inst      = w_hit ? r_mem[w_idx] : NOP;
  assign ld_ready  = (r_state == S_LOAD);
  assign load_done = (r_state == S_RUN);
  assign core_nrst = r_core_nrst;
  assign load_err  = r_load_err;
  assign pc_fault  = r_pc_fault;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default-size instance and a DEPTH=4 instance for the fill-without-last case.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_nrst, a_ld_valid, a_ld_ready, a_ld_last, a_reload;
  logic        a_core_nrst, a_load_done, a_load_err, a_pc_fault;
  logic [31:0] a_ld_data, a_pc, a_inst;

  logic        b_nrst, b_ld_valid, b_ld_ready, b_ld_last, b_reload;
  logic        b_core_nrst, b_load_done, b_load_err, b_pc_fault;
  logic [31:0] b_ld_data, b_pc, b_inst;

  imem_loader #(.DEPTH(256), .ADDR_WIDE(8)) u_a (
    .clk(clk), .nrst(a_nrst), .ld_valid(a_ld_valid), .ld_ready(a_ld_ready),
    .ld_data(a_ld_data), .ld_last(a_ld_last), .reload(a_reload), .pc(a_pc),
    .inst(a_inst), .core_nrst(a_core_nrst), .load_done(a_load_done),
    .load_err(a_load_err), .pc_fault(a_pc_fault)
  );

  imem_loader #(.DEPTH(4), .ADDR_WIDE(2)) u_b (
    .clk(clk), .nrst(b_nrst), .ld_valid(b_ld_valid), .ld_ready(b_ld_ready),
    .ld_data(b_ld_data), .ld_last(b_ld_last), .reload(b_reload), .pc(b_pc),
    .inst(b_inst), .core_nrst(b_core_nrst), .load_done(b_load_done),
    .load_err(b_load_err), .pc_fault(b_pc_fault)
  );

  // signal selectors: 0..5 on instance A, 10..15 on instance B
  localparam int INST = 0, RDY = 1, CNRST = 2, DONE = 3, ERR = 4, FLT = 5;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      INST:      return a_inst;
      RDY:       return {31'd0, a_ld_ready};
      CNRST:     return {31'd0, a_core_nrst};
      DONE:      return {31'd0, a_load_done};
      ERR:       return {31'd0, a_load_err};
      FLT:       return {31'd0, a_pc_fault};
      10 + INST: return b_inst;
      10 + RDY:  return {31'd0, b_ld_ready};
      10 + CNRST:return {31'd0, b_core_nrst};
      10 + DONE: return {31'd0, b_load_done};
      10 + ERR:  return {31'd0, b_load_err};
      10 + FLT:  return {31'd0, b_pc_fault};
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_v(input int sig, input logic [31:0] v, input string nm);
    chk_t c;
    c.sig = sig;
    c.exp = v;
    c.nm  = nm;
    q.push_back(c);
  endtask

  // monitor: drains expectations on the falling edge, away from the active edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] got;
      c   = q.pop_front();
      got = observe(c.sig);
      n_checks++;
      if (got !== c.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", c.nm, got, c.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [31:0] d, input logic last);
    a_ld_valid = 1'b1;
    a_ld_data  = d;
    a_ld_last  = last;
    tick();
    a_ld_valid = 1'b0;
    a_ld_last  = 1'b0;
  endtask

  task automatic a_pc_check(input logic [31:0] p, input logic [31:0] v, input string nm);
    a_pc = p;
    expect_v(INST, v, nm);
    tick();
  endtask

  task automatic a_expect_run(input string nm);
    expect_v(DONE, 32'd1, {nm, "_done"});
    expect_v(CNRST, 32'd1, {nm, "_core_nrst"});
    expect_v(RDY, 32'd0, {nm, "_rdy"});
  endtask

  logic [31:0] prog [3];
  logic [31:0] tog  [4];
  logic [31:0] bw   [5];

  initial begin
    prog[0] = 32'h0030_0093; prog[1] = 32'hFFF0_8093; prog[2] = 32'h0010_80B3;
    tog[0]  = 32'h1111_1113; tog[1]  = 32'h2222_2213; tog[2]  = 32'h3333_3313; tog[3] = 32'h4444_4413;
    bw[0]   = 32'hB000_0000; bw[1]   = 32'hB000_0001; bw[2]   = 32'hB000_0002;
    bw[3]   = 32'hB000_0003; bw[4]   = 32'hB000_0004;

    a_nrst = 1'b0; a_ld_valid = 1'b0; a_ld_data = '0; a_ld_last = 1'b0; a_reload = 1'b0; a_pc = '0;
    b_nrst = 1'b0; b_ld_valid = 1'b0; b_ld_data = '0; b_ld_last = 1'b0; b_reload = 1'b0; b_pc = '0;

    tick();
    expect_v(RDY,   32'd1, "rst_rdy");
    expect_v(CNRST, 32'd0, "rst_core_nrst");
    expect_v(DONE,  32'd0, "rst_done");
    expect_v(ERR,   32'd0, "rst_err");
    expect_v(FLT,   32'd0, "rst_fault");
    expect_v(INST,  NOP,   "rst_inst");
    tick();
    a_nrst = 1'b1;
    b_nrst = 1'b1;
    tick();

    // DEPTH=4 instance: fill without last, 5th beat must be refused
    for (int i = 0; i < 4; i++) begin
      b_ld_valid = 1'b1;
      b_ld_data  = bw[i];
      tick();
    end
    b_ld_data = bw[4];
    expect_v(10 + RDY, 32'd0, "b_full_rdy");
    expect_v(10 + ERR, 32'd1, "b_full_err");
    tick();
    expect_v(10 + DONE,  32'd1, "b_run_done");
    expect_v(10 + CNRST, 32'd1, "b_run_core_nrst");
    expect_v(10 + RDY,   32'd0, "b_run_rdy");
    tick();
    b_ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_pc = 32'(i * 4);
      expect_v(10 + INST, bw[i], $sformatf("b_inst%0d", i));
      tick();
    end
    b_pc = 32'h10;
    expect_v(10 + INST, NOP, "b_oor_inst");
    tick();
    expect_v(10 + FLT, 32'd1, "b_oor_fault");
    expect_v(10 + ERR, 32'd1, "b_err_sticky");
    tick();

    // three-word program on the default instance
    a_beat(prog[0], 1'b0);
    a_beat(prog[1], 1'b0);
    a_beat(prog[2], 1'b1);
    expect_v(RDY,   32'd0, "last_rdy");
    expect_v(CNRST, 32'd0, "hold_core_nrst");
    expect_v(DONE,  32'd0, "hold_done");
    tick();
    a_expect_run("run1");
    n_checks++;
    if (a_load_done !== 1'b1) begin
      n_errors++;
      $display("FAIL run1_done_direct: got %b", a_load_done);
    end
    n_checks++;
    if (a_core_nrst !== 1'b1) begin
      n_errors++;
      $display("FAIL run1_core_nrst_direct: got %b", a_core_nrst);
    end
    n_checks++;
    if (a_ld_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL run1_rdy_direct: got %b", a_ld_ready);
    end
    tick();
    a_pc_check(32'h0, prog[0], "inst_pc0");
    a_pc_check(32'h4, prog[1], "inst_pc4");
    a_pc_check(32'h8, prog[2], "inst_pc8");
    a_pc_check(32'hC, NOP, "inst_pc12");
    a_pc_check(32'h3FC, NOP, "inst_pc3fc");
    expect_v(FLT, 32'd0, "no_fault_beyond_count");
    expect_v(ERR, 32'd0, "no_err_with_last");

    // misaligned fetch
    a_pc_check(32'h2, NOP, "inst_misaligned");
    expect_v(FLT, 32'd1, "fault_misaligned");
    a_pc_check(32'h0, prog[0], "inst_after_fault");
    expect_v(FLT, 32'd1, "fault_sticky");
    tick();

    // reload pulse, then a one-word program
    a_reload = 1'b1;
    tick();
    a_reload = 1'b0;
    expect_v(CNRST, 32'd0, "reload_core_nrst");
    expect_v(DONE,  32'd0, "reload_done");
    expect_v(RDY,   32'd1, "reload_rdy");
    expect_v(FLT,   32'd0, "reload_fault_clr");
    expect_v(INST,  NOP,   "reload_inst_nop");
    tick();
    a_beat(32'h0050_0113, 1'b1);
    expect_v(RDY, 32'd0, "reload_last_rdy");
    tick();
    a_expect_run("run2");
    tick();
    a_pc_check(32'h0, 32'h0050_0113, "reload_new_word");
    a_pc_check(32'h4, NOP, "reload_pc4_nop");
    a_pc_check(32'h400, NOP, "inst_oor");
    expect_v(FLT, 32'd1, "fault_oor");
    tick();

    // reset mid-load after 2 of 4 beats
    a_reload = 1'b1;
    tick();
    a_reload = 1'b0;
    a_beat(32'hAAAA_0001, 1'b0);
    a_beat(32'hAAAA_0002, 1'b0);
    a_nrst = 1'b0;
    expect_v(CNRST, 32'd0, "midload_rst_core_nrst");
    expect_v(RDY,   32'd1, "midload_rst_rdy");
    tick();
    a_nrst = 1'b1;
    tick();
    a_beat(32'hCCCC_0013, 1'b1);
    tick();
    a_expect_run("run3");
    tick();
    a_pc_check(32'h4, NOP, "after_rst_pc4_nop");
    a_pc_check(32'h0, 32'hCCCC_0013, "after_rst_pc0");

    // asynchronous reset from RUN: visible before the next rising edge
    a_nrst = 1'b0;
    expect_v(CNRST, 32'd0, "async_core_nrst");
    expect_v(DONE,  32'd0, "async_done");
    expect_v(RDY,   32'd1, "async_rdy");
    expect_v(FLT,   32'd0, "async_fault");
    expect_v(INST,  NOP,   "async_inst");
    #1;
    n_checks++;
    if (a_core_nrst !== 1'b0) begin
      n_errors++;
      $display("FAIL async_core_nrst_direct: got %b", a_core_nrst);
    end
    n_checks++;
    if (a_load_done !== 1'b0) begin
      n_errors++;
      $display("FAIL async_done_direct: got %b", a_load_done);
    end
    n_checks++;
    if (a_ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL async_rdy_direct: got %b", a_ld_ready);
    end
    n_checks++;
    if (a_inst !== NOP) begin
      n_errors++;
      $display("FAIL async_inst_direct: got %h", a_inst);
    end
    tick();
    a_nrst = 1'b1;
    tick();

    // ld_valid on alternate cycles with junk data in the gaps
    for (int i = 0; i < 4; i++) begin
      a_beat(tog[i], (i == 3));
      if (i != 3) begin
        a_ld_data = 32'hDEAD_BEEF;
        tick();
      end
    end
    tick();
    a_expect_run("run4");
    tick();
    for (int i = 0; i < 4; i++)
      a_pc_check(32'(i * 4), tog[i], $sformatf("toggle_inst%0d", i));
    a_pc_check(32'h10, NOP, "toggle_count_end");

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
